// File: rtl/vram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// vram_arbiter_pkg
// Shared video-memory constants used by the VRAM arbiter, its write buffer and
// the rest of the video card: default VRAM geometry, write-buffer depth and the
// time-slot encoding.
// -----------------------------------------------------------------------------
package vram_arbiter_pkg;

    // 16 KB video memory, byte wide
    localparam int unsigned VRAM_AW     = 14;
    localparam int unsigned VRAM_DW     = 8;
    // CPU write-buffer depth (power of two, at least 2)
    localparam int unsigned VRAM_WDEPTH = 4;

    // Memory port time slot; the slot register alternates every cycle
    typedef enum logic {
        SLOT_VIDEO = 1'b0,
        SLOT_CPU   = 1'b1
    } slot_e;

    // True when n is a non-zero power of two
    function automatic logic is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage : vram_arbiter_pkg

// File: rtl/vram_wfifo.sv
// -----------------------------------------------------------------------------
// vram_wfifo
// CPU write buffer for the VRAM arbiter. Each entry is {address, data}.
// Ports:
//   clock, reset           : clock and synchronous active-high reset
//   push_i, push_addr_i,
//   push_data_i            : enqueue one write (ignored when full)
//   pop_i                  : dequeue the head entry (ignored when empty)
//   head_addr_o,
//   head_data_o            : head entry, valid while empty_o is low
//   full_o, empty_o        : occupancy flags, derived from the registered count
// -----------------------------------------------------------------------------
module vram_wfifo
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned AW    = VRAM_AW,
    parameter int unsigned DW    = VRAM_DW,
    parameter int unsigned DEPTH = VRAM_WDEPTH
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  logic [AW-1:0] push_addr_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [AW-1:0] head_addr_o,
    output logic [DW-1:0] head_data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = AW + DW;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    // Flags come from the registered count, so a pop while full only frees
    // space on the following cycle.
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    assign head_addr_o = mem_q[rd_ptr_q][EW-1:DW];
    assign head_data_o = mem_q[rd_ptr_q][DW-1:0];

    // Pointer and count next-state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, not reset: contents are only observed while non-empty
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {push_addr_i, push_data_i};
        end
    end

endmodule : vram_wfifo

// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port synchronous VRAM between the video scan-out stage and
// the CPU using alternating time slots. Video owns every other cycle and is
// never stalled; CPU writes are buffered in vram_wfifo and drained in CPU
// slots; a CPU read waits until all buffered writes have drained, so it always
// observes earlier writes.
// Ports:
//   clock, reset                      : clock, synchronous active-high reset
//   vid_address / vid_data            : video address in, byte out (2-cycle latency)
//   cpu_req, cpu_we, cpu_address,
//   cpu_wdata                         : CPU request, accepted when cpu_busy is low
//   cpu_busy                          : write buffer full or read outstanding
//   cpu_rdata, cpu_done               : read result (held) and its one-cycle strobe
//   mem_address, mem_wdata, mem_we    : RAM command for the current slot
//   mem_rdata                         : RAM data, one cycle after the address
// -----------------------------------------------------------------------------
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned AW     = VRAM_AW,
    parameter int unsigned DW     = VRAM_DW,
    parameter int unsigned WDEPTH = VRAM_WDEPTH
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] vid_address,
    output logic [DW-1:0] vid_data,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_address,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_busy,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_done,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    if (WDEPTH < 2 || !is_pow2(WDEPTH)) begin : g_bad_wdepth
        $error("vram_arbiter: WDEPTH must be a power of two and at least 2");
    end

    slot_e         slot_q, slot_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_issued_q, rd_issued_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          cpu_done_q, cpu_done_d;
    logic [DW-1:0] vid_data_q, vid_data_d;

    logic          wr_push;
    logic          rd_accept;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    // Request acceptance
    assign cpu_busy  = !reset && (fifo_full || rd_pend_q);
    assign wr_push   = cpu_req && !cpu_busy && cpu_we;
    assign rd_accept = cpu_req && !cpu_busy && !cpu_we;

    vram_wfifo #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (WDEPTH)
    ) u_wfifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (wr_push),
        .push_addr_i (cpu_address),
        .push_data_i (cpu_wdata),
        .pop_i       (fifo_pop),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Slot sequencing and RAM command; writes take priority over a read in
    // the CPU slot so a read never overtakes buffered writes.
    always_comb begin
        slot_d      = (slot_q == SLOT_VIDEO) ? SLOT_CPU : SLOT_VIDEO;
        mem_address = vid_address;
        mem_wdata   = '0;
        mem_we      = 1'b0;
        fifo_pop    = 1'b0;
        rd_issued_d = 1'b0;
        if (slot_q == SLOT_CPU && !reset) begin
            if (!fifo_empty) begin
                mem_address = head_addr;
                mem_wdata   = head_data;
                mem_we      = 1'b1;
                fifo_pop    = 1'b1;
            end else if (rd_pend_q && !rd_issued_q) begin
                mem_address = rd_addr_q;
                rd_issued_d = 1'b1;
            end
        end
    end

    // Read bookkeeping and returned data capture
    always_comb begin
        rd_pend_d   = rd_pend_q;
        rd_addr_d   = rd_addr_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_done_d  = 1'b0;
        vid_data_d  = vid_data_q;
        if (rd_accept) begin
            rd_pend_d = 1'b1;
            rd_addr_d = cpu_address;
        end
        // RAM data for a read issued last cycle is on mem_rdata now
        if (rd_issued_q) begin
            cpu_rdata_d = mem_rdata;
            cpu_done_d  = 1'b1;
            rd_pend_d   = 1'b0;
        end
        // A CPU slot always follows a video slot, whose RAM data is on mem_rdata
        if (slot_q == SLOT_CPU) begin
            vid_data_d = mem_rdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_q      <= SLOT_VIDEO;
            rd_pend_q   <= 1'b0;
            rd_issued_q <= 1'b0;
            rd_addr_q   <= '0;
            cpu_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            vid_data_q  <= '0;
        end else begin
            slot_q      <= slot_d;
            rd_pend_q   <= rd_pend_d;
            rd_issued_q <= rd_issued_d;
            rd_addr_q   <= rd_addr_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_done_q  <= cpu_done_d;
            vid_data_q  <= vid_data_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_done  = cpu_done_q;
    assign vid_data  = vid_data_q;

endmodule : vram_arbiter

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
// Scoreboard bench for vram_arbiter with a behavioural synchronous RAM.
// Video reads cover addresses 0..255 (never written, preloaded mem[n]=n);
// CPU writes go elsewhere, so video expectations are fixed by the preload.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 8;
    localparam int unsigned WD = 4;
    localparam int unsigned MEMSZ = 1 << AW;

    logic          clock;
    logic          reset;
    logic [AW-1:0] vid_address;
    logic [DW-1:0] vid_data;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_address;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_busy;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_done;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    vram_arbiter #(.AW(AW), .DW(DW), .WDEPTH(WD)) dut (
        .clock       (clock),
        .reset       (reset),
        .vid_address (vid_address),
        .vid_data    (vid_data),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_busy    (cpu_busy),
        .cpu_rdata   (cpu_rdata),
        .cpu_done    (cpu_done),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
        .mem_rdata   (mem_rdata)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] old;
    } wr_t;

    typedef struct packed {
        logic [31:0]   due;
        logic [DW-1:0] val;
    } vid_t;

    logic [DW-1:0] ram     [MEMSZ];
    logic [DW-1:0] ref_mem [MEMSZ];
    wr_t           wq[$];
    logic [DW-1:0] rq[$];
    vid_t          vq[$];
    int            cyc;
    int            busy_cnt;
    int            errors;
    int            checks;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle index since reset release; even cycles are video slots
    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc = reset ? 0 : cyc + 1;
        end
    end

    // Video scan-out: address steps once per video slot
    initial begin
        vid_address = '0;
        forever begin
            @(posedge clock);
            #1;
            vid_address = AW'((cyc / 2) % 256);
        end
    end

    // Synchronous single-port RAM, read-before-write
    initial begin
        logic [DW-1:0] rd;
        for (int i = 0; i < int'(MEMSZ); i++) ram[i] = DW'(i);
        mem_rdata = '0;
        forever begin
            @(posedge clock);
            rd = ram[mem_address];
            if (mem_we) ram[mem_address] = mem_wdata;
            mem_rdata <= rd;
        end
    end

    // Monitor and scoreboard, sampled on the falling edge
    initial begin
        int   rst_seen;
        wr_t  e;
        vid_t v;
        rst_seen = 0;
        busy_cnt = 0;
        for (int i = 0; i < int'(MEMSZ); i++) ref_mem[i] = DW'(i);
        forever begin
            @(negedge clock);
            if (reset) begin
                // Buffered writes are discarded: undo them in the reference
                while (wq.size() > 0) begin
                    e = wq.pop_back();
                    ref_mem[e.addr] = e.old;
                end
                rq.delete();
                vq.delete();
                check("rst_mem_we", 32'(mem_we), 32'd0);
                check("rst_busy", 32'(cpu_busy), 32'd0);
                if (rst_seen > 0) begin
                    check("rst_done", 32'(cpu_done), 32'd0);
                    check("rst_rdata", 32'(cpu_rdata), 32'd0);
                    check("rst_vid_data", 32'(vid_data), 32'd0);
                end
                rst_seen++;
            end else begin
                rst_seen = 0;
                if (cpu_done) begin
                    if (rq.size() > 0) check("cpu_rdata", 32'(cpu_rdata), 32'(rq.pop_front()));
                    else check("cpu_done_spurious", 32'(cpu_done), 32'd0);
                end
                check("cpu_busy", 32'(cpu_busy), 32'((wq.size() == WD) || (rq.size() > 0)));
                if (cpu_busy) busy_cnt++;
                if (cyc % 2 == 0) begin
                    check("vid_mem_we", 32'(mem_we), 32'd0);
                    check("vid_mem_addr", 32'(mem_address), 32'(vid_address));
                    v.due = 32'(cyc + 2);
                    v.val = DW'(vid_address);
                    vq.push_back(v);
                end else begin
                    check("cpu_mem_we", 32'(mem_we), 32'(wq.size() > 0));
                    if (mem_we && wq.size() > 0) begin
                        e = wq.pop_front();
                        check("wr_addr", 32'(mem_address), 32'(e.addr));
                        check("wr_data", 32'(mem_wdata), 32'(e.data));
                    end else if (wq.size() == 0 && rq.size() == 0) begin
                        check("idle_mem_addr", 32'(mem_address), 32'(vid_address));
                    end
                end
                if (vq.size() > 0 && vq[0].due == 32'(cyc)) begin
                    v = vq.pop_front();
                    check("vid_data", 32'(vid_data), 32'(v.val));
                end
                if (cpu_req && !cpu_busy) begin
                    if (cpu_we) begin
                        e.addr = cpu_address;
                        e.data = cpu_wdata;
                        e.old  = ref_mem[cpu_address];
                        wq.push_back(e);
                        ref_mem[cpu_address] = cpu_wdata;
                    end else begin
                        rq.push_back(ref_mem[cpu_address]);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Issue one CPU request and hold it until accepted (bounded)
    task automatic cpu_op(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        n = 0;
        cpu_req     = 1'b1;
        cpu_we      = we;
        cpu_address = a;
        cpu_wdata   = d;
        do begin
            @(negedge clock);
            n++;
        end while (cpu_busy && n < 64);
        if (cpu_busy) check("accept_timeout", 32'(cpu_busy), 32'd0);
        @(posedge clock);
        #1;
        cpu_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((wq.size() > 0 || rq.size() > 0) && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain", 32'(wq.size() + rq.size()), 32'd0);
        idle(2);
    endtask

    initial begin
        int b0;
        int start;
        int bad;
        errors      = 0;
        checks      = 0;
        reset       = 1'b1;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_address = '0;
        cpu_wdata   = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Idle CPU, video scan only
        idle(40);

        // Write then immediate read of the same address
        cpu_op(1'b1, 14'h0100, 8'h3A);
        cpu_op(1'b0, 14'h0100, 8'h00);
        wait_idle(50);
        check("raw_rdata", 32'(cpu_rdata), 32'h3A);
        cpu_op(1'b0, 14'h1234, 8'h00);
        wait_idle(50);
        check("rd_untouched", 32'(cpu_rdata), 32'h34);

        // Back-to-back write burst fills the buffer
        b0 = busy_cnt;
        for (int i = 0; i < 10; i++) cpu_op(1'b1, AW'(14'h0400 + i), DW'(8'hA0 + i));
        check("burst_busy", 32'(busy_cnt > b0), 32'd1);
        wait_idle(100);

        // Reset with writes buffered and a read pending
        for (int i = 0; i < 6; i++) cpu_op(1'b1, AW'(14'h0300 + i), DW'(8'h50 + i));
        cpu_op(1'b0, 14'h0300, 8'h00);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        idle(20);
        check("post_rst_busy", 32'(cpu_busy), 32'd0);
        cpu_op(1'b0, 14'h0305, 8'h00);
        wait_idle(50);
        check("rst_discard", 32'(cpu_rdata), 32'h05);
        cpu_op(1'b0, 14'h0300, 8'h00);
        wait_idle(50);
        check("rst_landed", 32'(cpu_rdata), 32'h50);

        // Random CPU traffic with continuous video scan
        start = cyc;
        while (cyc - start < 10000) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) cpu_op(1'b1, AW'(14'h2000 | ($urandom & 32'h1FFF)), DW'($urandom));
            else if (r < 8) cpu_op(1'b0, AW'($urandom), 8'h00);
            else idle(int'($urandom_range(1, 3)));
        end
        wait_idle(200);

        bad = 0;
        for (int i = 0; i < int'(MEMSZ); i++) if (ram[i] !== ref_mem[i]) bad++;
        check("ram_vs_ref", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vram_arbiter
